// File: rtl/word_serializer.sv
// Word serializer: pops 32-bit words from an upstream FIFO and sends each as
// a framed serial stream (start, 32 data bits LSB first, parity, stop).
module word_serializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_data,
   output logic        fifo_rd,
   output logic        ser_out,
   output logic        busy,
   output logic [15:0] words_sent
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   function automatic logic parity32(input logic [31:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  clk_cnt_r, clk_cnt_s;
   logic [4:0]  bit_idx_r, bit_idx_s;
   logic [31:0] shift_r, shift_s;
   logic        parity_r, parity_s;
   logic        ser_out_r, ser_out_s;
   logic        busy_r;
   logic [15:0] words_sent_r, words_sent_s;
   logic        pop_s;
   logic        bit_done_s;

   assign pop_s      = (state_r == IDLE) && enable && !fifo_empty && reset_n;
   assign bit_done_s = (clk_cnt_r == LAST_CNT);
   assign fifo_rd    = pop_s;
   assign ser_out    = ser_out_r;
   assign busy       = busy_r;
   assign words_sent = words_sent_r;

   // Next-state, bit timing, shift register and frame counter.
   always_comb begin
      state_s      = state_r;
      clk_cnt_s    = clk_cnt_r;
      bit_idx_s    = bit_idx_r;
      shift_s      = shift_r;
      parity_s     = parity_r;
      words_sent_s = words_sent_r;

      if (state_r == IDLE || bit_done_s) begin
         clk_cnt_s = 8'd0;
      end else begin
         clk_cnt_s = clk_cnt_r + 8'd1;
      end

      case (state_r)
         IDLE: begin
            if (pop_s) begin
               shift_s  = fifo_data;
               parity_s = parity32(fifo_data, PARITY_ODD);
               state_s  = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_done_s) begin
               bit_idx_s = 5'd0;
               state_s   = DATA;
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (!bit_done_s) begin
               state_s = DATA;
            end else if (bit_idx_r == 5'd31) begin
               state_s = PARITY;
            end else begin
               bit_idx_s = bit_idx_r + 5'd1;
               shift_s   = {1'b0, shift_r[31:1]};
            end
         end
         PARITY: begin
            if (bit_done_s) begin
               state_s = STOP;
            end else begin
               state_s = PARITY;
            end
         end
         STOP: begin
            if (bit_done_s) begin
               state_s      = IDLE;
               words_sent_s = words_sent_r + 16'd1;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Line level is decoded from the next state so ser_out can be a flop.
   always_comb begin
      ser_out_s = 1'b1;
      case (state_s)
         IDLE:    ser_out_s = 1'b1;
         START:   ser_out_s = 1'b0;
         DATA:    ser_out_s = shift_s[0];
         PARITY:  ser_out_s = parity_s;
         STOP:    ser_out_s = 1'b1;
         default: ser_out_s = 1'b1;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         clk_cnt_r    <= 8'd0;
         bit_idx_r    <= 5'd0;
         shift_r      <= 32'd0;
         parity_r     <= 1'b0;
         ser_out_r    <= 1'b1;
         busy_r       <= 1'b0;
         words_sent_r <= 16'd0;
      end else begin
         state_r      <= state_s;
         clk_cnt_r    <= clk_cnt_s;
         bit_idx_r    <= bit_idx_s;
         shift_r      <= shift_s;
         parity_r     <= parity_s;
         ser_out_r    <= ser_out_s;
         busy_r       <= (state_s != IDLE);
         words_sent_r <= words_sent_s;
      end
   end

endmodule
